// File: rtl/mmc_request_arbiter.sv
// mmc_request_arbiter: shares one SPI/MMC block-read controller between the Disk II track loader and the block-device port
// Ports:
//   CLK_14M, reset                     clock and synchronous active-high reset
//   i_disk_req/i_disk_track/o_disk_ack track-loader request, track number, completion pulse
//   i_blk_req/i_blk_num/o_blk_ack      block-port request, block number, completion pulse
//   o_xfer_err, o_err_sticky           timeout pulse with the ack, and latched timeout flag
//   o_owner, o_busy                    current owner (0 disk, 1 block) and grant-through-ack flag
//   o_mmc_*                            command side of the SPI controller
//   i_mmc_is_idle, i_mmc_ram_we        controller status and RAM write strobe
//   o_disk_buf_we, o_blk_buf_we        write strobe steered to the owner's buffer
module mmc_request_arbiter #(
  parameter logic [22:0] DISK_BASE_BLOCK = 23'h000000,
  parameter logic [22:0] BLK_BASE_BLOCK  = 23'h001000,
  parameter int          START_WAIT      = 16,
  parameter logic [23:0] TIMEOUT         = 24'd4000000
) (
  input  logic        CLK_14M,
  input  logic        reset,
  input  logic        i_disk_req,
  input  logic [5:0]  i_disk_track,
  output logic        o_disk_ack,
  input  logic        i_blk_req,
  input  logic [15:0] i_blk_num,
  output logic        o_blk_ack,
  output logic        o_xfer_err,
  output logic        o_err_sticky,
  output logic        o_owner,
  output logic        o_busy,
  output logic [5:0]  o_mmc_track,
  output logic        o_mmc_track_mode,
  output logic [22:0] o_mmc_block_to_read,
  output logic        o_mmc_block_read_cmd,
  input  logic        i_mmc_is_idle,
  input  logic        i_mmc_ram_we,
  output logic        o_disk_buf_we,
  output logic        o_blk_buf_we
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_DONE, S_ACK} state_t;
  state_t      r_state;
  logic [23:0] r_cnt;
  logic        r_last;
  logic        w_grant;
  logic        w_pick;
  assign w_grant = i_mmc_is_idle & (i_disk_req | i_blk_req);
  // on a tie the requester not served last wins
  assign w_pick = (i_disk_req & i_blk_req) ? ~r_last : i_blk_req;
  assign o_disk_buf_we = i_mmc_ram_we & o_busy & ~o_owner;
  assign o_blk_buf_we  = i_mmc_ram_we & o_busy & o_owner;
  always_ff @(posedge CLK_14M) begin
    if (reset) begin
      r_state              <= S_IDLE;
      r_cnt                <= '0;
      r_last               <= 1'b1;
      o_disk_ack           <= 1'b0;
      o_blk_ack            <= 1'b0;
      o_xfer_err           <= 1'b0;
      o_err_sticky         <= 1'b0;
      o_owner              <= 1'b0;
      o_busy               <= 1'b0;
      o_mmc_track          <= '0;
      o_mmc_track_mode     <= 1'b0;
      o_mmc_block_to_read  <= '0;
      o_mmc_block_read_cmd <= 1'b0;
    end else begin
      o_disk_ack <= 1'b0;
      o_blk_ack  <= 1'b0;
      o_xfer_err <= 1'b0;
      case (r_state)
        S_IDLE: if (w_grant) begin
          r_state              <= S_ISSUE;
          o_busy               <= 1'b1;
          o_owner              <= w_pick;
          r_last               <= w_pick;
          o_mmc_track_mode     <= ~w_pick;
          o_mmc_block_read_cmd <= w_pick;
          o_mmc_track          <= w_pick ? o_mmc_track : i_disk_track;
          o_mmc_block_to_read  <= w_pick ? BLK_BASE_BLOCK + {7'd0, i_blk_num} : DISK_BASE_BLOCK;
        end
        S_ISSUE: begin
          r_state <= S_WAIT_START;
          r_cnt   <= '0;
        end
        // a controller that never leaves idle found the data already cached
        S_WAIT_START: if (!i_mmc_is_idle) begin
          r_state              <= S_WAIT_DONE;
          r_cnt                <= '0;
          o_mmc_block_read_cmd <= 1'b0;
        end else if (r_cnt == 24'(START_WAIT - 1)) begin
          r_state              <= S_ACK;
          o_disk_ack           <= ~o_owner;
          o_blk_ack            <= o_owner;
          o_mmc_track_mode     <= 1'b0;
          o_mmc_block_read_cmd <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 24'd1;
        end
        // track_mode stays up here: the controller re-reads it to chain track blocks
        S_WAIT_DONE: if (i_mmc_is_idle || r_cnt == TIMEOUT - 24'd1) begin
          r_state          <= S_ACK;
          o_disk_ack       <= ~o_owner;
          o_blk_ack        <= o_owner;
          o_mmc_track_mode <= 1'b0;
          o_xfer_err       <= ~i_mmc_is_idle;
          o_err_sticky     <= o_err_sticky | ~i_mmc_is_idle;
        end else begin
          r_cnt <= r_cnt + 24'd1;
        end
        S_ACK: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mmc_request_arbiter.md
# mmc_request_arbiter

Shares the single SPI/MMC block-read controller between two requesters: the Disk II track loader, which needs whole 0x1A00-byte NIB tracks, and the block-device port, which needs single 512-byte blocks. The arbiter sequences the controller's `track_mode` and `block_read_cmd` inputs and returns a per-requester acknowledge. It also steers the controller's RAM write strobe to the buffer of the current owner. It sits between the two requesters and the SPI controller, in the CLK_14M domain.

## Interface
Parameters:
- `DISK_BASE_BLOCK`, default 23'h000000: first card block of the disk image. It is driven on `mmc_block_to_read` during track reads, and the controller adds track×13.
- `BLK_BASE_BLOCK`, default 23'h001000: card block offset added to `blk_num`.
- `START_WAIT`, default 16: cycles allowed for `mmc_is_idle` to fall after issue before the request counts as a cache hit.
- `TIMEOUT`, default 24'd4000000: maximum cycles in WAIT_DONE.

Ports:
- `CLK_14M` in 1: system clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `disk_req` in 1: level request; held high until `disk_ack`.
- `disk_track` in 6: requested track, 0–34; sampled at grant.
- `disk_ack` out 1: one-cycle completion pulse.
- `blk_req` in 1: level request; held high until `blk_ack`.
- `blk_num` in 16: requested block; sampled at grant.
- `blk_ack` out 1: one-cycle completion pulse.
- `xfer_err` out 1: pulses together with an ack when that transfer timed out.
- `err_sticky` out 1: set on any timeout; cleared only by reset.
- `owner` out 1: 0 = disk, 1 = block device. It is valid while `busy` is high.
- `busy` out 1: high from grant through ack.
- `mmc_track` out 6: to the controller's `track`.
- `mmc_track_mode` out 1: to the controller's `track_mode`.
- `mmc_block_to_read` out 23: to the controller's `block_to_read`.
- `mmc_block_read_cmd` out 1: to the controller's `block_read_cmd`.
- `mmc_is_idle` in 1: from the controller's `is_idle`.
- `mmc_ram_we` in 1: from the controller's `ram_we`.
- `disk_buf_we` out 1: RAM write strobe for the track buffer.
- `blk_buf_we` out 1: RAM write strobe for the block buffer.

## Operation
- States: IDLE → ISSUE → WAIT_START → WAIT_DONE → ACK → IDLE.
- IDLE:
  - A grant happens only when `mmc_is_idle`=1 and at least one request is high.
  - If both requests are high, the grant goes to the requester that was not granted last (round-robin). The "last" bit resets to block-device, so the disk wins the first tie.
  - On grant: latch `owner`; latch the track, or compute block = `BLK_BASE_BLOCK` + `blk_num` (23-bit, wraps modulo 2^23); set `busy`.
- ISSUE and WAIT_START, disk owner: drive `mmc_track`=latched track, `mmc_track_mode`=1, `mmc_block_to_read`=`DISK_BASE_BLOCK`, `mmc_block_read_cmd`=0.
- ISSUE and WAIT_START, block owner: drive `mmc_track_mode`=0, `mmc_block_to_read`=computed block, `mmc_block_read_cmd`=1.
- WAIT_START:
  - On `mmc_is_idle`=0, go to WAIT_DONE.
  - If `mmc_is_idle` has not fallen after `START_WAIT` cycles, the controller has judged the track or block unchanged (cached). Go straight to ACK with no error.
- WAIT_DONE:
  - `mmc_block_read_cmd` drops to 0.
  - `mmc_track_mode` stays at its issued value for the whole transfer, because the controller re-reads it after every block to chain a track.
  - `mmc_track` and `mmc_block_to_read` stay stable.
  - Exit on `mmc_is_idle`=1 → ACK.
  - When the timeout counter reaches `TIMEOUT` → ACK with `xfer_err`=1 and `err_sticky` set. The arbiter then waits in IDLE until `mmc_is_idle` returns.
- ACK:
  - Pulse the owner's ack for one cycle and clear `busy`.
  - `mmc_track_mode` returns to 0 and `mmc_track` holds its last value.
  - If the request is still high after ACK, it is a new request (requesters must drop `req` within one cycle of the ack).
- Write steering is combinational:
  - `disk_buf_we` = `mmc_ram_we` & `busy` & ~`owner`.
  - `blk_buf_we` = `mmc_ram_we` & `busy` & `owner`.
  - With no owner, both are 0.
- Request inputs are ignored while `busy`=1. A new `disk_track` or `blk_num` does not affect an in-flight transfer.

## Timing
- Reset values:
  - All outputs 0; state IDLE; `err_sticky` 0.
  - `mmc_track` = 0 and `mmc_block_to_read` = 0.
  - Both counters 0.
  - Round-robin "last" bit = block-device.
- Grant is registered: outputs to the controller are valid in the cycle after the request is sampled in IDLE. ISSUE lasts exactly one cycle.
- Minimum latency from request to ack on a cache hit: 1 (grant) + 1 (ISSUE) + `START_WAIT` + 1 (ACK) = 19 cycles.
- For a real transfer, ack follows `mmc_is_idle` rising by 1 cycle.
- Reset asserted mid-transfer: the arbiter returns to IDLE on the next edge with no ack. The SPI controller is reset by the same signal.

## Test plan
- **Disk track:** `disk_req`=1 with `disk_track`=5, and a controller model that holds `is_idle` low for 0x1A00 writes.
  - `mmc_track_mode`=1 throughout and `mmc_track`=5.
  - `disk_buf_we` pulses exactly 6656 times and `blk_buf_we` 0 times.
  - One `disk_ack`, 1 cycle after `is_idle` rises.
- **Block request:** `blk_req`=1 with `blk_num`=16'h0010.
  - `mmc_block_to_read`=23'h001010.
  - `mmc_block_read_cmd` high for 1 cycle of ISSUE plus the cycles until `is_idle` falls.
  - 512 `blk_buf_we` pulses, then `blk_ack`.
- **Simultaneous requests, twice in a row:** order is disk, block, disk, block. No overlap of `busy` periods.
- **Cache hit:** the model keeps `is_idle`=1. The ack arrives exactly 19 cycles after the request, with `xfer_err`=0.
- **Timeout:** with `TIMEOUT`=100, the model never re-raises `is_idle`.
  - Ack plus `xfer_err` 100 cycles into WAIT_DONE, and `err_sticky`=1.
  - The next request is not granted until `is_idle`=1.
- **Reset mid-transfer:** reset asserted during WAIT_DONE.
  - All outputs 0 on the next cycle and no ack.
  - A fresh request is then served normally.
